jb_imu: RTL and testbench

JB_IMU -- requirements
Module: jb_imu

---
 rtl/jb_imu.sv | 265 ++++++++++++++++++++++++++
 tb/tb_jb_imu.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jb_imu.sv
// -----------------------------------------------------------------------------
// jb_imu -- SPI (mode 0) master that reads one attitude/rate/acceleration frame
// from an IMU slave on request.
//
// One frame:
//   byte 0      : CMD_BYTE sent to the slave, the byte received is discarded
//   bytes 1..18 : 8'h00 sent, the received bytes form nine big-endian words
//                 roll, pitch, yaw, roll_rate, pitch_rate, yaw_rate,
//                 accel_x, accel_y, accel_z
//   byte 19     : (only with JB_IMU_CHECKSUM_EN defined) 8'h00 sent, the
//                 received byte must equal the mod-256 sum of bytes 1..18 for
//                 the outputs to be updated
//
// Optional feature macro: JB_IMU_CHECKSUM_EN (undefined by default).
//
// SPI timing (mode 0): SCK idles low. Each bit is a low half followed by a
// high half, each CLK_DIV clocks, so a byte occupies 16*CLK_DIV clocks in
// XFER. MISO is sampled on the rising SCK edge; MOSI changes on the falling
// edge (or in SETUP, before the first rise). Between bytes SS stays low and
// SCK stays low for BYTE_GAP clocks (GAP), followed by the first low half of
// the next byte.
//
// Ports:
//   clock       in   system clock
//   reset       in   asynchronous active-low reset
//   start       in   one-cycle frame request, honoured only in IDLE
//   roll..accel_z out 16-bit words, updated together at frame end
//   done        out  one-cycle frame-complete pulse
//   miso        in   SPI data from slave
//   mosi        out  SPI data to slave
//   sck         out  SPI clock
//   ss          out  SPI slave select, active-low
//
// Handshake: start is a request sampled on every clock edge while the FSM is
// in IDLE; it is ignored (not queued) in every other state. done is a pure
// one-clock strobe with no acknowledge; the nine words are valid from the
// done cycle onward and hold until the next successful frame.
//
// The FSM state register (state_q) is named and typed for direct probing.
// -----------------------------------------------------------------------------
module jb_imu #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned BYTE_GAP = 8,
  parameter logic [7:0]  CMD_BYTE = 8'h01
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic [15:0] roll,
  output logic [15:0] pitch,
  output logic [15:0] yaw,
  output logic [15:0] roll_rate,
  output logic [15:0] pitch_rate,
  output logic [15:0] yaw_rate,
  output logic [15:0] accel_x,
  output logic [15:0] accel_y,
  output logic [15:0] accel_z,
  output logic        done,
  input  logic        miso,
  output logic        mosi,
  output logic        sck,
  output logic        ss
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_XFER   = 3'd2,
    S_GAP    = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  // Timer must hold values up to max(CLK_DIV, BYTE_GAP) - 1.
  localparam int unsigned TMAX = (CLK_DIV > BYTE_GAP) ? CLK_DIV : BYTE_GAP;
  localparam int unsigned CW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [CW-1:0] DIV_LOAD = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LOAD = CW'(BYTE_GAP - 1);

  localparam logic [4:0] FIRST_DATA = 5'd1;
  localparam logic [4:0] LAST_DATA  = 5'd18;
`ifdef JB_IMU_CHECKSUM_EN
  localparam logic [4:0] LAST_BYTE  = 5'd19;
`else
  localparam logic [4:0] LAST_BYTE  = 5'd18;
`endif

  state_t        state_q;
  logic [CW-1:0] cnt_q;      // half-period / gap / setup timer, counts down
  logic [2:0]    bit_q;      // bit index within the current byte
  logic [4:0]    byte_q;     // byte index within the frame
  logic [6:0]    tx_q;       // bits of the current byte still to be sent
  logic [7:0]    rx_q;       // receive shift register
  logic [7:0]    sum_q;      // running mod-256 sum of data bytes
  logic [143:0]  shadow_q;   // received data bytes, byte 1 ends up in [143:136]
  logic          sck_q;
  logic          ss_q;
  logic          mosi_q;
  logic          done_q;
  logic [15:0]   roll_q, pitch_q, yaw_q;
  logic [15:0]   roll_rate_q, pitch_rate_q, yaw_rate_q;
  logic [15:0]   accel_x_q, accel_y_q, accel_z_q;

  // Shadow contents including the byte completing on this falling edge, so
  // that without the checksum byte the last data byte lands in the outputs
  // in the same edge that enters FINISH.
  logic          is_data_byte;
  logic [143:0]  shadow_nxt;
  logic          frame_ok;

  always_comb begin
    is_data_byte = (byte_q >= FIRST_DATA) && (byte_q <= LAST_DATA);
    shadow_nxt   = shadow_q;
    if (is_data_byte) begin
      shadow_nxt = {shadow_q[135:0], rx_q};
    end
`ifdef JB_IMU_CHECKSUM_EN
    // rx_q holds the checksum byte when the last byte completes.
    frame_ok = (rx_q == sum_q);
`else
    frame_ok = 1'b1;
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      byte_q       <= '0;
      tx_q         <= '0;
      rx_q         <= '0;
      sum_q        <= '0;
      shadow_q     <= '0;
      sck_q        <= 1'b0;
      ss_q         <= 1'b1;
      mosi_q       <= 1'b0;
      done_q       <= 1'b0;
      roll_q       <= '0;
      pitch_q      <= '0;
      yaw_q        <= '0;
      roll_rate_q  <= '0;
      pitch_rate_q <= '0;
      yaw_rate_q   <= '0;
      accel_x_q    <= '0;
      accel_y_q    <= '0;
      accel_z_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          ss_q   <= 1'b1;
          sck_q  <= 1'b0;
          mosi_q <= 1'b0;
          if (start) begin
            state_q  <= S_SETUP;
            ss_q     <= 1'b0;
            mosi_q   <= CMD_BYTE[7];
            tx_q     <= CMD_BYTE[6:0];
            cnt_q    <= DIV_LOAD;
            bit_q    <= '0;
            byte_q   <= '0;
            sum_q    <= '0;
          end
        end

        S_SETUP: begin
          if (cnt_q == '0) begin
            state_q <= S_XFER;
            cnt_q   <= DIV_LOAD;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end

        S_XFER: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            cnt_q <= DIV_LOAD;
            if (!sck_q) begin
              // Rising edge: sample MISO.
              sck_q <= 1'b1;
              rx_q  <= {rx_q[6:0], miso};
            end else begin
              // Falling edge: present next bit or close the byte.
              sck_q <= 1'b0;
              if (bit_q != 3'd7) begin
                bit_q  <= bit_q + 3'd1;
                mosi_q <= tx_q[6];
                tx_q   <= {tx_q[5:0], 1'b0};
              end else begin
                bit_q    <= '0;
                shadow_q <= shadow_nxt;
                if (is_data_byte) begin
                  sum_q <= sum_q + rx_q;
                end
                if (byte_q == LAST_BYTE) begin
                  state_q <= S_FINISH;
                  ss_q    <= 1'b1;
                  done_q  <= 1'b1;
                  mosi_q  <= 1'b0;
                  if (frame_ok) begin
                    roll_q       <= shadow_nxt[143:128];
                    pitch_q      <= shadow_nxt[127:112];
                    yaw_q        <= shadow_nxt[111:96];
                    roll_rate_q  <= shadow_nxt[95:80];
                    pitch_rate_q <= shadow_nxt[79:64];
                    yaw_rate_q   <= shadow_nxt[63:48];
                    accel_x_q    <= shadow_nxt[47:32];
                    accel_y_q    <= shadow_nxt[31:16];
                    accel_z_q    <= shadow_nxt[15:0];
                  end
                end else begin
                  // All bytes after the command are 8'h00.
                  state_q <= S_GAP;
                  byte_q  <= byte_q + 5'd1;
                  cnt_q   <= GAP_LOAD;
                  tx_q    <= '0;
                  mosi_q  <= 1'b0;
                end
              end
            end
          end
        end

        S_GAP: begin
          if (cnt_q == '0) begin
            state_q <= S_XFER;
            cnt_q   <= DIV_LOAD;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end

        S_FINISH: begin
          state_q <= S_IDLE;
          ss_q    <= 1'b1;
          sck_q   <= 1'b0;
        end

        default: begin
          state_q <= S_IDLE;
          ss_q    <= 1'b1;
          sck_q   <= 1'b0;
          mosi_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sck        = sck_q;
  assign ss         = ss_q;
  assign mosi       = mosi_q;
  assign done       = done_q;
  assign roll       = roll_q;
  assign pitch      = pitch_q;
  assign yaw        = yaw_q;
  assign roll_rate  = roll_rate_q;
  assign pitch_rate = pitch_rate_q;
  assign yaw_rate   = yaw_rate_q;
  assign accel_x    = accel_x_q;
  assign accel_y    = accel_y_q;
  assign accel_z    = accel_z_q;

endmodule

// File: tb/tb_jb_imu.sv
// Bench for jb_imu: behavioural SPI slave plus frame model, per-cycle compare.
`timescale 1ns/1ps
module tb_jb_imu;
  localparam int         CLK_DIV  = 4;
  localparam int         BYTE_GAP = 8;
  localparam logic [7:0] CMD      = 8'h01;
`ifdef JB_IMU_CHECKSUM_EN
  localparam int NB = 20;
  localparam bit CS = 1'b1;
`else
  localparam int NB = 19;
  localparam bit CS = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic miso  = 1'b0;
  logic [15:0] roll, pitch, yaw, roll_rate, pitch_rate, yaw_rate;
  logic [15:0] accel_x, accel_y, accel_z;
  logic done, mosi, sck, ss;

  always #10 clk = ~clk;   // 50 MHz

  int cyc = 0;
  always @(posedge clk) cyc++;

  jb_imu #(.CLK_DIV(CLK_DIV), .BYTE_GAP(BYTE_GAP), .CMD_BYTE(CMD)) dut (
    .clock(clk), .reset(rst_n), .start(start),
    .roll(roll), .pitch(pitch), .yaw(yaw),
    .roll_rate(roll_rate), .pitch_rate(pitch_rate), .yaw_rate(yaw_rate),
    .accel_x(accel_x), .accel_y(accel_y), .accel_z(accel_z),
    .done(done), .miso(miso), .mosi(mosi), .sck(sck), .ss(ss)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [143:0] act, input logic [143:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // ---------------- behavioural slave + frame model ----------------
  logic [7:0]  fb [0:19];
  logic [15:0] exp_w [0:8];
  logic [143:0] exp_q[$];   // frame results awaiting their done cycle
  int   pat_mode = 0;       // 0: 00,01,02,... ; 1: random bytes
  int   cs_mode  = 0;       // 0: correct checksum ; 1: forced cs_val
  logic [7:0] cs_val = 8'h00;
  bit   active = 1'b0;
  int   bitcnt = 0;
  int   last_rise = 0, last_fall = 0, ss_fall_cyc = 0, end_cyc = 0;
  int   frame_ends = 0;
  int   done_cnt = 0;
  logic [7:0] mcap = 8'h00;

  initial for (int i = 0; i < 9; i++) exp_w[i] = 16'h0000;

  function automatic logic [7:0] sum18();
    logic [7:0] s;
    s = 8'h00;
    for (int k = 1; k <= 18; k++) s = s + fb[k];
    return s;
  endfunction

  // Expected words after a frame: updated only when the checksum (if any) matches.
  function automatic logic [143:0] frame_result();
    logic [143:0] r;
    if (!CS || fb[19] == sum18()) begin
      for (int i = 0; i < 9; i++) exp_w[i] = {fb[2*i+1], fb[2*i+2]};
    end
    r = '0;
    for (int i = 0; i < 9; i++) r = {r[127:0], exp_w[i]};
    return r;
  endfunction

  always @(negedge rst_n) begin
    active = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 9; i++) exp_w[i] = 16'h0000;
  end

  always @(negedge ss) begin
    if (rst_n) begin
      for (int k = 0; k < 20; k++)
        fb[k] = (pat_mode == 0) ? k[7:0] : 8'($urandom_range(0, 255));
      if (CS) fb[19] = (cs_mode == 0) ? sum18() : cs_val;
      active      = 1'b1;
      bitcnt      = 0;
      ss_fall_cyc = cyc;
      miso        = fb[0][7];
    end
  end

  always @(posedge sck) begin
    if (active && rst_n) begin
      if (bitcnt % 8 != 0)  chk("sck_period", 144'(cyc - last_rise), 144'(2*CLK_DIV));
      else if (bitcnt > 0)  chk("byte_gap", 144'(cyc - last_fall), 144'(BYTE_GAP + CLK_DIV));
      else                  chk("setup_time", 144'(cyc - ss_fall_cyc), 144'(2*CLK_DIV));
      last_rise = cyc;
      mcap = {mcap[6:0], mosi};
      bitcnt++;
      if (bitcnt % 8 == 0) chk("mosi_byte", 144'(mcap), (bitcnt == 8) ? 144'(CMD) : 144'(0));
    end
  end

  always @(negedge sck) begin
    if (active && rst_n) begin
      chk("sck_high", 144'(cyc - last_rise), 144'(CLK_DIV));
      last_fall = cyc;
      if (bitcnt == NB*8) begin
        active  = 1'b0;
        end_cyc = cyc;
        exp_q.push_back(frame_result());
        frame_ends++;
      end else begin
        miso = fb[bitcnt/8][7 - (bitcnt % 8)];
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [143:0] exp_out = '0;
  always @(negedge clk) begin
    logic exp_done;
    exp_done = 1'b0;
    if (exp_q.size() > 0) begin
      exp_out  = exp_q.pop_front();
      exp_done = 1'b1;
    end
    if (!rst_n) exp_out = '0;
    chk("done", 144'(done), 144'(exp_done));
    chk("words", {roll, pitch, yaw, roll_rate, pitch_rate, yaw_rate, accel_x, accel_y, accel_z},
        exp_out);
    if (exp_done) chk("ss_finish", 144'(ss), 144'(1));
    else if (active && bitcnt > 0) chk("ss_low", 144'(ss), 144'(0));
    if (done === 1'b1) done_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_frame(input string name);
    int f0;
    bit got;
    f0  = frame_ends;
    got = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (frame_ends != f0) begin got = 1'b1; break; end
    end
    chk({name, "_timeout"}, 144'(got), 144'(1));
  endtask

  task automatic check_reset_state(input string name);
    chk({name, "_ss"},    144'(ss),   144'(1));
    chk({name, "_sck"},   144'(sck),  144'(0));
    chk({name, "_mosi"},  144'(mosi), 144'(0));
    chk({name, "_done"},  144'(done), 144'(0));
    chk({name, "_words"}, {roll, pitch, yaw, roll_rate, pitch_rate, yaw_rate,
                           accel_x, accel_y, accel_z}, 144'(0));
  endtask

  task automatic check_incr_literals(input string name);
    chk({name, "_roll"},       144'(roll),       144'(16'h0102));
    chk({name, "_pitch"},      144'(pitch),      144'(16'h0304));
    chk({name, "_yaw"},        144'(yaw),        144'(16'h0506));
    chk({name, "_roll_rate"},  144'(roll_rate),  144'(16'h0708));
    chk({name, "_pitch_rate"}, 144'(pitch_rate), 144'(16'h090A));
    chk({name, "_yaw_rate"},   144'(yaw_rate),   144'(16'h0B0C));
    chk({name, "_accel_x"},    144'(accel_x),    144'(16'h0D0E));
    chk({name, "_accel_y"},    144'(accel_y),    144'(16'h0F10));
    chk({name, "_accel_z"},    144'(accel_z),    144'(16'h1112));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #3ms;
    failures++;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    int d0, e1, f0;
    logic [15:0] saved_roll;
    bit reached;

    // Reset low 100 ns.
    #50;
    check_reset_state("reset");
    #50 rst_n = 1'b1;
    wait_cycles(3);

    // Directed frame with incrementing slave bytes.
    pat_mode = 0; cs_mode = 0;
    d0 = done_cnt;
    pulse_start();
    wait_frame("frame1");
    wait_cycles(3);
    check_incr_literals("frame1");
    chk("frame1_done_pulses", 144'(done_cnt - d0), 144'(1));

    // Extra start mid-frame is ignored.
    pat_mode = 1;
    d0 = done_cnt;
    pulse_start();
    wait_cycles(300);
    pulse_start();
    wait_frame("midstart");
    wait_cycles(30);
    chk("midstart_done_pulses", 144'(done_cnt - d0), 144'(1));

    // Reset asserted during byte 10.
    pat_mode = 0;
    d0 = done_cnt;
    pulse_start();
    reached = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (active && bitcnt >= 81) begin reached = 1'b1; break; end
    end
    chk("byte10_reached", 144'(reached), 144'(1));
    #3 rst_n = 1'b0;
    #1 check_reset_state("midreset");
    #100 rst_n = 1'b1;
    wait_cycles(60);
    chk("midreset_no_done", 144'(done_cnt - d0), 144'(0));
    chk("midreset_ss_idle", 144'(ss), 144'(1));
    pulse_start();
    wait_frame("after_reset");
    wait_cycles(3);
    check_incr_literals("after_reset");

`ifdef JB_IMU_CHECKSUM_EN
    // Good checksum with random data, then incrementing data with bad checksum.
    pat_mode = 1; cs_mode = 0;
    pulse_start();
    wait_frame("cs_good");
    wait_cycles(3);
    saved_roll = exp_w[0];
    pat_mode = 0; cs_mode = 1; cs_val = 8'h00;
    d0 = done_cnt;
    pulse_start();
    wait_frame("cs_bad");
    wait_cycles(3);
    chk("cs_bad_done_pulses", 144'(done_cnt - d0), 144'(1));
    chk("cs_bad_roll_kept", 144'(roll), 144'(saved_roll));
    // Incrementing data with the correct 8'hAB checksum updates again.
    cs_mode = 1; cs_val = 8'hAB;
    pulse_start();
    wait_frame("cs_ab");
    wait_cycles(3);
    check_incr_literals("cs_ab");
    cs_mode = 0;
`else
    saved_roll = 16'h0000;
`endif

    // Randomised frames, random idle spacing, random ignored mid-frame starts.
    for (int it = 0; it < 10; it++) begin
      pat_mode = 1;
      cs_mode  = CS ? int'($urandom_range(0, 1)) : 0;
      cs_val   = 8'($urandom_range(0, 255));
      wait_cycles($urandom_range(0, 15));
      d0 = done_cnt;
      pulse_start();
      if ($urandom_range(0, 1) == 1) begin
        wait_cycles($urandom_range(10, 900));
        pulse_start();
      end
      wait_frame("rand");
      wait_cycles(5);
      chk("rand_done_pulses", 144'(done_cnt - d0), 144'(1));
    end

    // start held high: a new frame begins on the first clock back in IDLE.
    pat_mode = 1; cs_mode = 0;
    @(posedge clk); #1 start = 1'b1;
    wait_frame("held1");
    e1 = end_cyc;
    wait_frame("held2");
    start = 1'b0;
    chk("held_restart_latency", 144'(ss_fall_cyc - e1), 144'(2));
    f0 = frame_ends;
    wait_cycles(40);
    chk("held_release_no_frame", 144'(frame_ends - f0), 144'(0));
    chk("held_release_ss", 144'(ss), 144'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
